hamming_encoding_storage: RTL and testbench

SECDED extended Hamming (16,11) codec for the storage/channel path.
- Encoder registers an 11-bit data word into a 16-bit codeword.
- Decoder registers a received 16-bit channel word, corrects any single-bit error, detects double-bit errors, and returns the 11-bit data.
- The two paths are independent and operate on the same clock; the channel model or storage array sits between them.

---
 rtl/hamming_pkg.sv | 56 +++++
 rtl/hamming_encoding_storage_decoder.sv | 38 +++
 rtl/hamming_encoding_storage.sv | 74 +++++++
 tb/tb_hamming_encoding_storage.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared constants, types and pure functions for the SECDED (16,11) codec.
// Bit 0 is overall parity; bits 1..15 are Hamming positions 1..15.
package hamming_pkg;

    localparam int DATA_W = 11;
    localparam int CODE_W = 16;
    localparam int SYN_W  = 4;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CODE_W-1:0] code_t;
    typedef logic [SYN_W-1:0]  syn_t;

    localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    function automatic code_t encode(input data_t d);
        code_t c;
        logic  p;
        c = '0;
        for (int i = 0; i < DATA_W; i++) begin
            c[DATA_POS[i]] = d[i];
        end
        // Check bit 2^k never covers another check position, so order is free.
        for (int k = 0; k < SYN_W; k++) begin
            p = 1'b0;
            for (int j = 1; j < CODE_W; j++) begin
                if (((j >> k) & 1) == 1) begin
                    p = p ^ c[j];
                end
            end
            c[1 << k] = p;
        end
        c[0] = ^c[CODE_W-1:1];
        return c;
    endfunction

    function automatic syn_t syndrome(input code_t c);
        syn_t s;
        s = '0;
        for (int j = 1; j < CODE_W; j++) begin
            if (c[j]) begin
                s = s ^ SYN_W'(j);
            end
        end
        return s;
    endfunction

    function automatic data_t extract(input code_t c);
        data_t d;
        d = '0;
        for (int i = 0; i < DATA_W; i++) begin
            d[i] = c[DATA_POS[i]];
        end
        return d;
    endfunction

endpackage

// File: rtl/hamming_encoding_storage_decoder.sv
// Combinational SECDED decode: syndrome, single-bit correction, data extract.
// Status outputs exist only when HAMMING_STATUS_EN is defined.
module hamming_decoder
    import hamming_pkg::*;
(
    input  code_t channel_word,
`ifdef HAMMING_STATUS_EN
    output logic  err_single,
    output logic  err_double,
    output syn_t  syndrome_out,
`endif
    output data_t data
);

    syn_t  syn;
    logic  p_err;
    code_t fixed;

    always_comb begin
        syn   = syndrome(channel_word);
        p_err = ^channel_word;
        fixed = channel_word;
        // Odd parity with a nonzero syndrome points at the flipped position.
        if (syn != '0 && p_err) begin
            fixed[syn] = ~fixed[syn];
        end
        data = extract(fixed);
    end

`ifdef HAMMING_STATUS_EN
    always_comb begin
        err_single   = p_err;
        err_double   = (syn != '0) && !p_err;
        syndrome_out = syn;
    end
`endif

endmodule

// File: rtl/hamming_encoding_storage.sv
// SECDED (16,11) encoder and decoder, each registered with 1-cycle latency.
// Define HAMMING_STATUS_EN to add err_single, err_double and syndrome_out.
module hamming_encoding_storage
    import hamming_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  data_t data_in,
    output code_t code_word_out,
    input  code_t channel_word,
`ifdef HAMMING_STATUS_EN
    output logic  err_single,
    output logic  err_double,
    output syn_t  syndrome_out,
`endif
    output data_t data_out
);

    code_t code_d, code_q;
    data_t data_d, data_q;
    data_t dec_data;

`ifdef HAMMING_STATUS_EN
    logic es_d, es_q, ed_d, ed_q;
    syn_t syn_d, syn_q;
`endif

    hamming_decoder u_dec (
        .channel_word (channel_word),
`ifdef HAMMING_STATUS_EN
        .err_single   (es_d),
        .err_double   (ed_d),
        .syndrome_out (syn_d),
`endif
        .data         (dec_data)
    );

    always_comb begin
        code_d = encode(data_in);
        data_d = dec_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= '0;
            data_q <= '0;
        end else begin
            code_q <= code_d;
            data_q <= data_d;
        end
    end

`ifdef HAMMING_STATUS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            es_q  <= 1'b0;
            ed_q  <= 1'b0;
            syn_q <= '0;
        end else begin
            es_q  <= es_d;
            ed_q  <= ed_d;
            syn_q <= syn_d;
        end
    end

    assign err_single   = es_q;
    assign err_double   = ed_q;
    assign syndrome_out = syn_q;
`endif

    assign code_word_out = code_q;
    assign data_out      = data_q;

endmodule

// File: tb/tb_hamming_encoding_storage.sv
// Scoreboard bench for hamming_encoding_storage with a behavioural SECDED model.
// Honours HAMMING_STATUS_EN when checking the optional status outputs.
module tb_hamming_encoding_storage;

    typedef logic [10:0] data_t;
    typedef logic [15:0] code_t;

    typedef struct {
        code_t code;
        data_t data;
        logic  es;
        logic  ed;
        logic [3:0] sy;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    data_t data_in = '0;
    code_t channel_word = '0;
    code_t code_word_out;
    data_t data_out;
`ifdef HAMMING_STATUS_EN
    logic       err_single;
    logic       err_double;
    logic [3:0] syndrome_out;
`endif

    int errors = 0;
    int checks = 0;
    exp_t sb[$];

    localparam int POS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    hamming_encoding_storage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (data_in),
        .code_word_out (code_word_out),
        .channel_word  (channel_word),
`ifdef HAMMING_STATUS_EN
        .err_single    (err_single),
        .err_double    (err_double),
        .syndrome_out  (syndrome_out),
`endif
        .data_out      (data_out)
    );

    always #5 clk = ~clk;

    // Codeword = data bits placed, check bits chosen to cancel the syndrome, even parity.
    function automatic code_t m_enc(input data_t d);
        code_t c;
        logic [3:0] s;
        c = '0;
        s = '0;
        for (int i = 0; i < 11; i++) begin
            if (d[i]) begin
                c[POS[i]] = 1'b1;
                s = s ^ 4'(POS[i]);
            end
        end
        for (int k = 0; k < 4; k++) c[1 << k] = s[k];
        c[0] = ^c;
        return c;
    endfunction

    function automatic data_t m_ext(input code_t c);
        data_t d;
        for (int i = 0; i < 11; i++) d[i] = c[POS[i]];
        return d;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input data_t d, input code_t ch, input logic lb,
                         input code_t ec, input data_t edat,
                         input logic es, input logic ed, input logic [3:0] sy);
        exp_t e;
        @(negedge clk);
        data_in = d;
        channel_word = lb ? code_word_out : ch;
        e.code = ec;
        e.data = edat;
        e.es = es;
        e.ed = ed;
        e.sy = sy;
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("code_word_out", code_word_out, e.code);
            chk("data_out", 16'(data_out), 16'(e.data));
`ifdef HAMMING_STATUS_EN
            chk("err_single", 16'(err_single), 16'(e.es));
            chk("err_double", 16'(err_double), 16'(e.ed));
            chk("syndrome_out", 16'(syndrome_out), 16'(e.sy));
`endif
        end
    end

    initial begin
        data_t d, prev;
        code_t c;
        int a, b;
        #2;
        chk("reset code", code_word_out, 16'h0000);
        chk("reset data", 16'(data_out), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        drive(11'h000, 16'h0000, 1'b0, 16'h0000, 11'h000, 1'b0, 1'b0, 4'd0);
        drive(11'h001, 16'h000F, 1'b0, 16'h000F, 11'h001, 1'b0, 1'b0, 4'd0);
        drive(11'h7FF, 16'hFFFF, 1'b0, 16'hFFFF, 11'h7FF, 1'b0, 1'b0, 4'd0);
        drive(11'h7FF, 16'h7FFF, 1'b0, 16'hFFFF, 11'h7FF, 1'b1, 1'b0, 4'd15);
        drive(11'h000, 16'h0001, 1'b0, 16'h0000, 11'h000, 1'b1, 1'b0, 4'd0);
        drive(11'h001, 16'hFFF9, 1'b0, 16'h000F, 11'h7FF, 1'b0, 1'b1, 4'd3);
        drive(11'h001, 16'h0010, 1'b0, 16'h000F, 11'h000, 1'b1, 1'b0, 4'd4);

        for (int r = 0; r < 4; r++) begin
            d = data_t'($urandom);
            c = m_enc(d);
            for (int bt = 0; bt < 16; bt++) begin
                drive(d, c ^ (16'h1 << bt), 1'b0, c, d, 1'b1, 1'b0, 4'(bt));
            end
        end

        for (int r = 0; r < 40; r++) begin
            d = data_t'($urandom);
            c = m_enc(d);
            a = $urandom_range(0, 15);
            b = (a + $urandom_range(1, 15)) % 16;
            c = c ^ (16'h1 << a) ^ (16'h1 << b);
            drive(d, c, 1'b0, m_enc(d), m_ext(c), 1'b0, 1'b1, 4'(a ^ b));
        end

        drive(11'h7FF, 16'hFFFF, 1'b0, 16'hFFFF, 11'h7FF, 1'b0, 1'b0, 4'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async reset code", code_word_out, 16'h0000);
        chk("async reset data", 16'(data_out), 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        chk("held reset code", code_word_out, 16'h0000);
        chk("held reset data", 16'(data_out), 16'h0000);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        prev = data_t'($urandom);
        drive(prev, 16'h0000, 1'b0, m_enc(prev), 11'h000, 1'b0, 1'b0, 4'd0);
        for (int n = 0; n < 1000; n++) begin
            d = data_t'($urandom);
            drive(d, 16'h0000, 1'b1, m_enc(d), prev, 1'b0, 1'b0, 4'd0);
            prev = d;
        end

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard drained", 16'(sb.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
